// File: rtl/mem_stage_bus.sv
// Memory pipeline stage with a single-outstanding request/response data bus.
// Decodes the access size and alignment, drives byte-lane steered bus requests,
// extracts and extends load data, and registers the MEM/WB boundary.
// A wait counter bounds every transaction; expiry raises a bus error pulse.
module mem_stage_bus #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reg_write_m_i,
  input  logic [1:0]                result_src_m_i,
  input  logic                      mem_write_m_i,
  input  logic [2:0]                funct3_m_i,
  input  logic [XLEN-1:0]           alu_result_m_i,
  input  logic [XLEN-1:0]           rs2_data_m_i,
  input  logic [XLEN-1:0]           pc_plus_4_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_i,
  output logic                      bus_req_valid_o,
  output logic                      bus_req_we_o,
  input  logic                      bus_req_ready_i,
  output logic [XLEN-1:0]           bus_req_addr_o,
  output logic [XLEN-1:0]           bus_req_wdata_o,
  output logic [XLEN/8-1:0]         bus_req_be_o,
  input  logic                      bus_rsp_valid_i,
  input  logic [XLEN-1:0]           bus_rsp_rdata_i,
  output logic                      stall_m_o,
  output logic                      reg_write_w_o,
  output logic [1:0]                result_src_w_o,
  output logic [XLEN-1:0]           read_data_w_o,
  output logic [XLEN-1:0]           alu_result_w_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_w_o,
  output logic [XLEN-1:0]           pc_plus_4_w_o,
  output logic                      misalign_o,
  output logic                      bus_err_o
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int IW   = $clog2(XLEN);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Byte enables for an access of 2**size bytes, steered to the addressed lane.
  function automatic logic [BEW-1:0] lane_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [BEW-1:0] m;
    int nb;
    nb = 32'd1 << size;
    for (int i = 0; i < BEW; i++) begin
      m[i] = (i < nb);
    end
    return m << off;
  endfunction

  // Repeat the low 8*2**size bits of d across the whole bus word.
  function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] d, input logic [1:0] size);
    logic [XLEN-1:0] r;
    int nbits;
    nbits = 32'd8 << size;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = d[IW'(i % nbits)];
    end
    return r;
  endfunction

  // Sign- or zero-extend the low 8*2**size bits of d to XLEN.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] size, input logic uns);
    logic [XLEN-1:0] r;
    logic sgn;
    int nbits;
    nbits = 32'd8 << size;
    if (nbits > XLEN) begin
      nbits = XLEN;
    end
    sgn = ~uns & d[IW'(nbits - 1)];
    for (int i = 0; i < XLEN; i++) begin
      r[i] = (i < nbits) ? d[i] : sgn;
    end
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_store_s, is_load_s, is_mem_s;
  logic            illegal_s, misalign_s, misalign_idle_s;
  logic [OFFW-1:0] offset_s, align_mask_s;
  logic            valid_s, stall_s, complete_s, timeout_s;
  logic [XLEN-1:0] load_ext_s;

  logic                      reg_write_d, misalign_d, bus_err_d;
  logic [1:0]                result_src_d;
  logic [XLEN-1:0]           read_data_d, alu_result_d, pc_plus_4_d;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_d;

  assign is_store_s = mem_write_m_i;
  assign is_load_s  = (result_src_m_i == 2'b01) & ~mem_write_m_i;
  assign is_mem_s   = is_store_s | is_load_s;
  assign offset_s   = alu_result_m_i[OFFW-1:0];
  // 111 is never a legal access; double and unsigned word need a 64-bit bus.
  assign illegal_s  = (funct3_m_i == 3'b111) ||
                      ((XLEN == 32) && ((funct3_m_i == 3'b011) || (funct3_m_i == 3'b110)));

  // Low address bits that must be zero for the decoded access size.
  always_comb begin
    align_mask_s = '0;
    case (funct3_m_i[1:0])
      2'b00:   align_mask_s = '0;
      2'b01:   align_mask_s = OFFW'(1);
      2'b10:   align_mask_s = OFFW'(3);
      2'b11:   align_mask_s = OFFW'(7);
      default: align_mask_s = '0;
    endcase
  end

  assign misalign_s      = is_mem_s & (illegal_s | ((offset_s & align_mask_s) != '0));
  // Alignment is judged only when a new op is considered; in-flight ops were aligned.
  assign misalign_idle_s = (state_q == S_IDLE) & misalign_s;

  assign load_ext_s = extend(bus_rsp_rdata_i >> {offset_s, 3'b000}, funct3_m_i[1:0], funct3_m_i[2]);

  // Transaction FSM and wait counter; a completing response beats the timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_s    = 1'b0;
    complete_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_mem_s && !misalign_s) begin
          valid_s = 1'b1;
          if (bus_req_ready_i && is_store_s) begin
            complete_s = 1'b1;
          end else if (bus_req_ready_i) begin
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        valid_s = 1'b1;
        if (bus_req_ready_i && is_store_s) begin
          complete_s = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = S_IDLE;
        end else if (bus_req_ready_i) begin
          state_d = S_RESP;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus_rsp_valid_i) begin
          complete_s = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stall_s = ((state_q != S_IDLE) | (is_mem_s & ~misalign_s)) & ~complete_s & ~timeout_s;

  // Reset gates the handshake outputs so nothing leaks out while rst_n is low.
  assign bus_req_valid_o = rst_n & valid_s;
  assign stall_m_o       = rst_n & stall_s;
  assign bus_req_we_o    = is_store_s;
  assign bus_req_addr_o  = alu_result_m_i;
  assign bus_req_wdata_o = replicate(rs2_data_m_i, funct3_m_i[1:0]);
  assign bus_req_be_o    = lane_mask(funct3_m_i[1:0], offset_s);

  // MEM/WB next value: error pulse, bubble while stalled, or the instruction itself.
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    read_data_d  = '0;
    alu_result_d = '0;
    rd_addr_d    = '0;
    pc_plus_4_d  = '0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    if (timeout_s) begin
      bus_err_d = 1'b1;
    end else if (stall_s) begin
      bus_err_d = 1'b0;
    end else if (misalign_idle_s) begin
      misalign_d = 1'b1;
    end else begin
      reg_write_d  = reg_write_m_i;
      result_src_d = result_src_m_i;
      read_data_d  = is_load_s ? load_ext_s : '0;
      alu_result_d = alu_result_m_i;
      rd_addr_d    = rd_addr_m_i;
      pc_plus_4_d  = pc_plus_4_m_i;
    end
  end

  // State, counter and MEM/WB register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      reg_write_w_o  <= 1'b0;
      result_src_w_o <= 2'b00;
      read_data_w_o  <= '0;
      alu_result_w_o <= '0;
      rd_addr_w_o    <= '0;
      pc_plus_4_w_o  <= '0;
      misalign_o     <= 1'b0;
      bus_err_o      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      reg_write_w_o  <= reg_write_d;
      result_src_w_o <= result_src_d;
      read_data_w_o  <= read_data_d;
      alu_result_w_o <= alu_result_d;
      rd_addr_w_o    <= rd_addr_d;
      pc_plus_4_w_o  <= pc_plus_4_d;
      misalign_o     <= misalign_d;
      bus_err_o      <= bus_err_d;
    end
  end

endmodule
